// File: rtl/rs75_serial_encoder.sv
// Streaming systematic RS(7,5) encoder over GF(8) (x^3+x+1): 5 message symbols in, 7-symbol codeword out.
// Optional macro RS_ENC_ERR_INJECT_EN adds err_inject/err_pattern to corrupt symbols as they are loaded.
module rs75_serial_encoder #(
    parameter int unsigned SYMBOL_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [SYMBOL_WIDTH-1:0] msg_sym,
`ifdef RS_ENC_ERR_INJECT_EN
    input  logic                    err_inject,
    input  logic [SYMBOL_WIDTH-1:0] err_pattern,
`endif
    output logic                    cw_valid,
    input  logic                    cw_ready,
    output logic [SYMBOL_WIDTH-1:0] cw_sym,
    output logic                    cw_last,
    output logic                    busy
);

    localparam int unsigned K     = 5;
    localparam int unsigned CNT_W = $clog2(K);
    localparam logic [SYMBOL_WIDTH-1:0] G1 = 3'b110;
    localparam logic [SYMBOL_WIDTH-1:0] G0 = 3'b011;

    typedef enum logic [1:0] {
        ST_MSG  = 2'd0,
        ST_PAR1 = 2'd1,
        ST_PAR0 = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [SYMBOL_WIDTH-1:0] r1_q, r1_d, r0_q, r0_d;
    logic [SYMBOL_WIDTH-1:0] cw_sym_q, cw_sym_d;
    logic                    cw_valid_q, cw_valid_d;
    logic                    cw_last_q, cw_last_d;
    logic                    busy_q, busy_d;

    logic                    out_free;
    logic                    load;
    logic [SYMBOL_WIDTH-1:0] load_sym;
    logic [SYMBOL_WIDTH-1:0] fb;
    logic [SYMBOL_WIDTH-1:0] inj_pat;

    // GF(8) multiply: carry-less product reduced by x^4 = x^2+x and x^3 = x+1
    function automatic logic [SYMBOL_WIDTH-1:0] gmul(input logic [SYMBOL_WIDTH-1:0] a,
                                                     input logic [SYMBOL_WIDTH-1:0] b);
        logic [4:0] p;
        p = 5'b0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) p = p ^ (5'(a) << i);
        end
        if (p[4]) p = p ^ 5'b10110;
        if (p[3]) p = p ^ 5'b01011;
        return p[2:0];
    endfunction

`ifdef RS_ENC_ERR_INJECT_EN
    assign inj_pat = err_inject ? err_pattern : '0;
`else
    assign inj_pat = '0;
`endif

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        r1_d       = r1_q;
        r0_d       = r0_q;
        cw_sym_d   = cw_sym_q;
        cw_valid_d = cw_valid_q;
        cw_last_d  = cw_last_q;
        busy_d     = busy_q;
        msg_ready  = 1'b0;
        load       = 1'b0;
        load_sym   = msg_sym;
        out_free   = !cw_valid_q || cw_ready;
        fb         = msg_sym ^ r1_q;

        if (cw_valid_q && cw_ready && cw_last_q) busy_d = 1'b0;

        case (state_q)
            ST_MSG: begin
                msg_ready = out_free;
                if (msg_valid && out_free) begin
                    // LFSR always advances on the clean message symbol
                    r1_d     = r0_q ^ gmul(fb, G1);
                    r0_d     = gmul(fb, G0);
                    load     = 1'b1;
                    load_sym = msg_sym;
                    busy_d   = 1'b1;
                    if (sym_cnt_q == CNT_W'(K - 1)) begin
                        sym_cnt_d = '0;
                        state_d   = ST_PAR1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAR1: begin
                if (out_free) begin
                    load     = 1'b1;
                    load_sym = r1_q;
                    state_d  = ST_PAR0;
                end
            end
            ST_PAR0: begin
                if (out_free) begin
                    load     = 1'b1;
                    load_sym = r0_q;
                    r1_d     = '0;
                    r0_d     = '0;
                    state_d  = ST_MSG;
                end
            end
            default: state_d = ST_MSG;
        endcase

        // one-entry output register
        if (load) begin
            cw_valid_d = 1'b1;
            cw_sym_d   = load_sym ^ inj_pat;
            cw_last_d  = (state_q == ST_PAR0);
        end else if (out_free) begin
            cw_valid_d = 1'b0;
            cw_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_MSG;
            sym_cnt_q  <= '0;
            r1_q       <= '0;
            r0_q       <= '0;
            cw_sym_q   <= '0;
            cw_valid_q <= 1'b0;
            cw_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            r1_q       <= r1_d;
            r0_q       <= r0_d;
            cw_sym_q   <= cw_sym_d;
            cw_valid_q <= cw_valid_d;
            cw_last_q  <= cw_last_d;
            busy_q     <= busy_d;
        end
    end

    assign cw_sym   = cw_sym_q;
    assign cw_valid = cw_valid_q;
    assign cw_last  = cw_last_q;
    assign busy     = busy_q;

endmodule

// File: doc/rs75_serial_encoder.md
Name: rs75_serial_encoder

Overview:
- Streaming systematic RS(7,5) encoder over GF(2^3), primitive polynomial x^3+x+1 (alpha = 3'b010).
- Accepts 5 message symbols, one per handshake, and emits a 7-symbol codeword: the 5 message symbols unchanged, then 2 parity symbols.
- Sits on the transmit side, ahead of the channel; its codewords give zero syndromes S1 = c(alpha) and S2 = c(alpha^2) in the receive-side syndrome logic.
- Generator polynomial g(x) = x^2 + alpha^4 x + alpha^3, with g1 = 3'b110 and g0 = 3'b011.

Parameters:
- SYMBOL_WIDTH, 3, bits per GF(8) symbol. Fixed; GF multipliers are hardwired for this field.
- N, 7, codeword length in symbols.
- K, 5, message length in symbols. N-K = 2 parity symbols.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- msg_valid  in  1  msg_sym is valid this cycle.
- msg_ready  out  1  encoder accepts msg_sym this cycle.
- msg_sym  in  3  message symbol; highest-degree symbol (m4) first.
- cw_valid  out  1  cw_sym is valid; registered output.
- cw_ready  in  1  downstream accepts cw_sym.
- cw_sym  out  3  codeword symbol, order m4,m3,m2,m1,m0,p1,p0.
- cw_last  out  1  high with p0, the 7th symbol.
- busy  out  1  high from the first accepted message symbol until p0 is accepted downstream.

Behaviour:
- Reset (async assert, sync release): state=MSG, sym_cnt=0, r1=r0=0, cw_valid=0, cw_sym=0, cw_last=0, busy=0.
- Output register: one-entry. out_free = !cw_valid || cw_ready. Register loads only when out_free. When out_free and nothing is loaded, cw_valid clears.
- MSG state:
  - msg_ready = out_free.
  - On accept (msg_valid && msg_ready):
    - f = msg_sym ^ r1
    - r1 <= r0 ^ gmul(f, 3'b110)
    - r0 <= gmul(f, 3'b011)
    - cw_sym <= msg_sym; cw_valid <= 1; sym_cnt++.
  - On the 5th accept (sym_cnt == K-1): sym_cnt <= 0; go to PAR1.
- PAR1 state:
  - msg_ready = 0.
  - When out_free: cw_sym <= r1, cw_valid <= 1, go to PAR0.
- PAR0 state:
  - msg_ready = 0.
  - When out_free: cw_sym <= r0, cw_last <= 1, cw_valid <= 1; clear r1 and r0; go to MSG.
- Throughput and latency:
  - With cw_ready held at 1, one codeword every 7 cycles with no bubbles.
  - Latency from accept to cw_valid is 1 cycle.
- GF multiply is combinational polynomial multiply mod x^3+x+1. Additions are XOR.
- Backpressure: cw_sym, cw_valid and cw_last stay stable while cw_valid && !cw_ready. The LFSR never advances without an accept.
- Message gaps: msg_valid low mid-message holds state and sym_cnt. The encoder does not time out.
- cw_last clears on the next load after p0, or when the output drains.
- Reset mid-codeword aborts it. No partial parity is emitted after reset.

Optional Feature:
- Macro: RS_ENC_ERR_INJECT_EN.
- Defined:
  - Adds input err_inject (1 bit) and input err_pattern (3 bits).
  - Each symbol loaded into the output register is XORed with err_pattern when err_inject is high in the load cycle.
  - The LFSR always uses the uncorrupted msg_sym.
  - Used to drive known single-symbol errors into decoder benches.
- Undefined: ports absent; output is the pure codeword.

Test Plan:
1. Reset, then send 1,0,0,0,0 with cw_ready=1 -> cw_sym = 1,0,0,0,0,6,2 (p1=3'b110, p0=3'b010); cw_last high only on the 7th symbol; cw_valid high on 7 consecutive cycles.
2. Send all-zero message -> 0,0,0,0,0,0,0. Then send 1,0,0,0,0 immediately after -> 1,0,0,0,0,6,2, proving the LFSR cleared after p0.
3. Random messages, cw_ready toggled randomly, msg_valid gaps -> every codeword gives c(alpha)=0 and c(alpha^2)=0. Output stays stable whenever valid && !ready. No symbol is lost or duplicated.
4. Assert rst after the 3rd accepted message symbol, then send 1,0,0,0,0 -> outputs are 0 during reset, then 1,0,0,0,0,6,2.
5. cw_ready=0 while in PAR1 -> msg_ready=0. A pending msg_valid is not accepted until p0 has been loaded.
6. With RS_ENC_ERR_INJECT_EN, message 1,0,0,0,0, err_inject pulsed with err_pattern=3'b001 on the 2nd symbol -> 1,1,0,0,0,6,2 (parity unchanged).
